// File: rtl/seg7_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_capture: debounces an asynchronous 7-segment bus, decodes the glyph  |
// | to hex and hands entries out on a valid/ready port. Build option:         |
// | SEG7_CAPTURE_FIFO_EN selects a 4-entry FIFO store instead of one register.|
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module seg7_capture #(
    parameter int STABLE_CYCLES = 16,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
    input  logic       out_ready,
    input  logic       ovf_clr,
    output logic       out_valid,
    output logic [3:0] out_value,
    output logic       out_invalid,
    output logic [6:0] out_pattern,
    output logic       overflow,
    output logic [7:0] accept_cnt
);
    localparam logic [15:0] c_stable    = 16'(STABLE_CYCLES);
    localparam logic [15:0] c_stable_m1 = 16'(STABLE_CYCLES - 1);

    logic [6:0]  r_sync1;
    logic [6:0]  r_sync2;
    logic [6:0]  r_prev;
    logic [15:0] r_cnt;
    logic [6:0]  r_last;
    logic        r_ovf;
    logic [7:0]  r_acnt;

    logic [6:0]  w_sample;
    logic        w_same;
    logic [15:0] w_run;
    logic        w_accept;
    logic [4:0]  w_dec;
    logic        w_xfer;
    logic        w_full;
    logic        w_push;
    logic        w_drop;

    // Returns {invalid, value}; unknown glyphs decode to value 0.
    function automatic logic [4:0] f_decode(input logic [6:0] pat);
        case (pat)
            7'h3F:   f_decode = 5'h00;
            7'h06:   f_decode = 5'h01;
            7'h5B:   f_decode = 5'h02;
            7'h4F:   f_decode = 5'h03;
            7'h66:   f_decode = 5'h04;
            7'h6D:   f_decode = 5'h05;
            7'h7D:   f_decode = 5'h06;
            7'h07:   f_decode = 5'h07;
            7'h7F:   f_decode = 5'h08;
            7'h6F:   f_decode = 5'h09;
            7'h77:   f_decode = 5'h0A;
            7'h7C:   f_decode = 5'h0B;
            7'h39:   f_decode = 5'h0C;
            7'h5E:   f_decode = 5'h0D;
            7'h79:   f_decode = 5'h0E;
            7'h71:   f_decode = 5'h0F;
            default: f_decode = 5'h10;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 7'h00;
            r_sync2 <= 7'h00;
        end else begin
            r_sync1 <= seg_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2 ^ {7{ACTIVE_LOW}};

    // r_cnt is the run length ending at r_prev; w_run includes this cycle's sample.
    assign w_same   = (w_sample == r_prev);
    assign w_run    = !w_same ? 16'd1 :
                      (r_cnt == c_stable) ? c_stable : r_cnt + 16'd1;
    assign w_accept = w_same && (r_cnt == c_stable_m1) && (w_sample != r_last);
    assign w_dec    = f_decode(w_sample);

    assign w_xfer = out_valid && out_ready;
    assign w_push = w_accept && (!w_full || w_xfer);
    assign w_drop = w_accept && w_full && !w_xfer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 7'h00;
            r_cnt  <= 16'd0;
            r_last <= 7'h00;
            r_ovf  <= 1'b0;
            r_acnt <= 8'd0;
        end else begin
            r_prev <= w_sample;
            r_cnt  <= w_run;
            if (w_accept) begin
                r_last <= w_sample;
                r_acnt <= r_acnt + 8'd1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign overflow   = r_ovf;
    assign accept_cnt = r_acnt;

`ifdef SEG7_CAPTURE_FIFO_EN
    logic [11:0] r_mem [0:3];
    logic [1:0]  r_rd;
    logic [1:0]  r_wr;
    logic [2:0]  r_count;

    assign w_full = (r_count == 3'd4);

    // A push into a full FIFO during a pop reuses the slot being read out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= 12'h000;
            end
            r_rd    <= 2'd0;
            r_wr    <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= {w_dec, w_sample};
                r_wr        <= r_wr + 2'd1;
            end
            if (w_xfer) begin
                r_rd <= r_rd + 2'd1;
            end
            r_count <= r_count + 3'(w_push) - 3'(w_xfer);
        end
    end

    assign out_valid                              = (r_count != 3'd0);
    assign {out_invalid, out_value, out_pattern} = r_mem[r_rd];
`else
    logic       r_valid;
    logic [3:0] r_value;
    logic       r_invalid;
    logic [6:0] r_pattern;

    assign w_full = r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_value   <= 4'd0;
            r_invalid <= 1'b0;
            r_pattern <= 7'h00;
        end else if (w_push) begin
            r_valid   <= 1'b1;
            r_value   <= w_dec[3:0];
            r_invalid <= w_dec[4];
            r_pattern <= w_sample;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign out_value   = r_value;
    assign out_invalid = r_invalid;
    assign out_pattern = r_pattern;
`endif

endmodule
`default_nettype wire
